// File: rtl/if_fetch_queue.sv
// Instruction prefetch queue: fetches sequential words from a combinational ROM
// into a DEPTH-entry {pc, inst} FIFO and presents the head entry to IF/ID.
module if_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       rom_ce,
    output logic [31:0]                rom_addr,
    input  logic [31:0]                rom_inst,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic                       if_valid,
    input  logic                       if_ready,
    output logic [31:0]                if_pc,
    output logic [31:0]                if_inst,
    output logic [$clog2(DEPTH):0]     q_count,
    output logic                       o_dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t          r_state;
    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_pc_mem   [DEPTH];
    logic [31:0]     r_inst_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;

    logic            w_pop;
    logic            w_push;
    logic            w_full;

    assign w_full = (r_count == C_FULL);
    assign w_pop  = (r_count != '0) && if_ready;
    // A full queue may still fetch when the head leaves in the same cycle.
    assign w_push = rst && (r_state == S_RUN) && !redirect_valid && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_state <= S_RUN;
            if (redirect_valid) begin
                // Redirect flushes everything, including a head accepted this cycle.
                r_fetch_pc <= {redirect_pc[31:2], 2'b00};
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr   <= r_wr_ptr + AW'(1);
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + (AW+1)'(1);
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - (AW+1)'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]   <= r_fetch_pc;
            r_inst_mem[r_wr_ptr] <= rom_inst;
        end
    end

    assign rom_ce      = w_push;
    assign rom_addr    = r_fetch_pc;
    assign if_valid    = (r_count != '0);
    assign if_pc       = if_valid ? r_pc_mem[r_rd_ptr]   : 32'h00000000;
    assign if_inst     = if_valid ? r_inst_mem[r_rd_ptr] : 32'h00000000;
    assign q_count     = r_count;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: queue-level reference model predicts fetches,
// a monitor checks every delivered instruction against the expected stream.
module tb_if_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h00000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic [2:0]  q_count;
    logic        o_dbg_state;

    int total = 0;
    int bad   = 0;
    int pops  = 0;

    logic [63:0] exp_q[$];
    logic [31:0] m_pc;
    bit          m_run;

    if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .rom_ce         (rom_ce),
        .rom_addr       (rom_addr),
        .rom_inst       (rom_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .q_count        (q_count),
        .o_dbg_state    (o_dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h0BADF00D;
    endfunction

    assign rom_inst = rom_fn(rom_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted head must be the next expected entry.
    always @(negedge clk) begin
        #2;
        if (if_valid === 1'b1 && if_ready === 1'b1) begin
            pops++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_unexpected: got pc %h expected no entry", if_pc);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("pop_pc", if_pc, e[63:32]);
                check("pop_inst", if_inst, e[31:0]);
            end
        end
    end

    // Drive one cycle, check visible state, then advance the model for the edge.
    task automatic cycle(input bit r_n, input bit rv, input logic [31:0] rpc, input bit rdy);
        bit exp_ce;
        int sz;
        @(negedge clk);
        rst            = r_n;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if_ready       = rdy;
        #1;
        sz = exp_q.size();
        exp_ce = r_n && m_run && !rv && (sz < DEPTH || (sz == DEPTH && rdy));
        check("rom_ce", {31'd0, rom_ce}, {31'd0, exp_ce});
        check("rom_addr", rom_addr, m_pc);
        check("q_count", {29'd0, q_count}, sz);
        check("if_valid", {31'd0, if_valid}, {31'd0, sz != 0});
        check("state", {31'd0, o_dbg_state}, {31'd0, m_run});
        if (sz == 0) begin
            check("idle_pc", if_pc, 32'h0);
            check("idle_inst", if_inst, 32'h0);
        end
        #2;
        if (!r_n) begin
            exp_q.delete();
            m_pc  = RESET_PC;
            m_run = 1'b0;
        end else begin
            if (rv) begin
                exp_q.delete();
                m_pc = {rpc[31:2], 2'b00};
            end else if (exp_ce) begin
                exp_q.push_back({m_pc, rom_fn(m_pc)});
                m_pc = m_pc + 32'd4;
            end
            m_run = 1'b1;
        end
    endtask

    task automatic fill_to(input int n);
        for (int i = 0; i < 12 && exp_q.size() != n; i++) cycle(1, 0, 32'h0, 0);
        check("fill_reached", exp_q.size(), n);
    endtask

    initial begin
        rst = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; if_ready = 1'b0;
        m_pc = RESET_PC; m_run = 1'b0;

        cycle(0, 0, 32'h0, 1);
        cycle(0, 1, 32'h80, 1);
        // Fill with IF/ID stalled, then stream with one push and one pop per cycle.
        for (int i = 0; i < 8; i++) cycle(1, 0, 32'h0, 0);
        check("full_head_pc", if_pc, 32'h0);
        check("full_head_inst", if_inst, rom_fn(32'h0));
        for (int i = 0; i < 10; i++) cycle(1, 0, 32'h0, 1);
        // Redirect with a pop while full, then redirect with three queued.
        fill_to(DEPTH);
        cycle(1, 1, 32'h00000200, 1);
        cycle(1, 0, 32'h0, 0);
        fill_to(3);
        cycle(1, 1, 32'h00000103, 0);
        for (int i = 0; i < 6; i++) cycle(1, 0, 32'h0, 1);
        // Address wrap through zero.
        cycle(1, 1, 32'hFFFFFFF8, 1);
        for (int i = 0; i < 7; i++) cycle(1, 0, 32'h0, 1);
        // Mid-stream reset with two queued, then a redirect while idle.
        cycle(1, 1, 32'h00000300, 0);
        fill_to(2);
        cycle(0, 0, 32'h0, 1);
        cycle(1, 1, 32'h00000041, 1);
        for (int i = 0; i < 6; i++) cycle(1, 0, 32'h0, $urandom_range(0, 1));

        for (int i = 0; i < 800; i++) begin
            bit          r_n;
            bit          rv;
            logic [31:0] rpc;
            r_n = ($urandom_range(0, 79) != 0);
            rv  = ($urandom_range(0, 7) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFE0 | $urandom_range(0, 31)) : $urandom;
            cycle(r_n, rv, rpc, $urandom_range(0, 3) != 0);
        end

        check("enough_pops", {31'd0, pops > 200}, 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, prefetch queue entries (power of two, 2..16).
REQ-002 The module SHALL have parameter RESET_PC, default 32'h00000000, first fetch address after reset.
REQ-003 The module SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 The module SHALL have port rst  input  1  reset, synchronous, active-low (0 = reset asserted).
REQ-005 The module SHALL have port rom_ce  output  1  chip enable to instruction ROM.
REQ-006 The module SHALL have port rom_addr  output  32  byte address to instruction ROM.
REQ-007 The module SHALL have port rom_inst  input  32  instruction word from ROM, valid combinationally in the same cycle as rom_addr.
REQ-008 The module SHALL have port redirect_valid  input  1  branch/exception redirect request.
REQ-009 The module SHALL have port redirect_pc  input  32  redirect target address.
REQ-010 The module SHALL have port if_valid  output  1  head entry valid toward IF/ID.
REQ-011 The module SHALL have port if_ready  input  1  IF/ID accepts head entry this cycle.
REQ-012 The module SHALL have port if_pc  output  32  address of head instruction.
REQ-013 The module SHALL have port if_inst  output  32  head instruction word.
REQ-014 The module SHALL have port q_count  output  log2(DEPTH)+1  current queue occupancy.

Function
REQ-015 Internal state SHALL be fetch_pc (32 bit), queue storage of {pc, inst} pairs, read/write pointers, occupancy count, and FSM with states IDLE and RUN.
REQ-016 rom_addr SHALL equal fetch_pc at all times.
REQ-017 In IDLE, rom_ce SHALL be 0; IDLE SHALL transition to RUN on the next edge unconditionally.
REQ-018 In RUN, rom_ce SHALL be 1 when count < DEPTH, or count == DEPTH and a pop occurs this cycle, and redirect_valid == 0; otherwise 0.
REQ-019 When rom_ce == 1, at the clock edge {fetch_pc, rom_inst} SHALL be written to the queue tail and fetch_pc SHALL increment by 4 (mod 2^32; 32'hFFFFFFFC wraps to 32'h00000000).
REQ-020 A pop SHALL occur when if_valid == 1 and if_ready == 1; the head entry is removed at that edge.
REQ-021 Simultaneous push and pop SHALL leave count unchanged, including at count == DEPTH (full) and count == 1.
REQ-022 if_valid SHALL be 1 iff count != 0; when if_valid == 0, if_pc and if_inst SHALL be 32'h00000000.
REQ-023 Queue output SHALL be registered: an instruction pushed at edge N is first visible on if_inst after edge N (one-cycle fetch latency); no bypass from rom_inst to if_inst.
REQ-024 redirect_valid == 1 SHALL, at the edge, discard all queue entries (count := 0), set fetch_pc := {redirect_pc[31:2], 2'b00}, and suppress push that cycle (rom_ce == 0).
REQ-025 Redirect SHALL take priority over push and pop; any pop handshake in the redirect cycle is still considered consumed by IF/ID, queue still empties.
REQ-026 if_valid SHALL be 0 in the cycle after a redirect; the first target instruction SHALL appear two edges after the redirect edge.
REQ-027 Redirect asserted while in IDLE SHALL update fetch_pc and keep the IDLE->RUN transition.
REQ-028 Pop with count == 0 SHALL be impossible (if_valid == 0); push with count == DEPTH and no pop SHALL be impossible (rom_ce == 0).

Reset
REQ-029 With rst == 0 at an edge: FSM := IDLE, fetch_pc := RESET_PC, count := 0, pointers := 0; all other inputs ignored.
REQ-030 During and after reset until first push: rom_ce = 0, rom_addr = RESET_PC, if_valid = 0, if_pc = 0, if_inst = 0, q_count = 0.
REQ-031 Reset asserted mid-operation SHALL discard queue contents and pending redirects identically to power-on reset.

Verification
REQ-032 Reset release, if_ready = 0, ROM word = addr: rom_ce low 1 cycle, then addrs 0,4,8,12 fetched; q_count reaches 4 and rom_ce drops to 0; if_pc = 0, if_inst = 0x00000000.
REQ-033 Full queue, if_ready held 1: one push and one pop every cycle, q_count stays 4, if_pc sequence 0,4,8,... with no gaps.
REQ-034 Redirect to 32'h00000103 with 3 entries queued: next cycle q_count = 0, if_valid = 0, rom_addr = 0x00000100; two edges later if_pc = 0x00000100.
REQ-035 RESET_PC = 32'hFFFFFFF8, if_ready = 1: if_pc sequence FFFFFFF8, FFFFFFFC, 00000000, 00000004.
REQ-036 Redirect and pop in same cycle at count == DEPTH: queue empties, no stale entry appears on if_pc afterward.
REQ-037 rst driven low for one cycle mid-stream with 2 entries queued: next cycle all outputs at reset values, fetch restarts at RESET_PC.
